io_interval_timer: RTL and testbench



---
 rtl/io_interval_timer.sv | 191 +++++++++++++++++++
 tb/tb_io_interval_timer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_interval_timer.sv
// io_interval_timer
//
// Programmable interval timer on the processor's non-cacheable IO bus.
// The timer has a prescaler that produces a tick every PRESCALE+1 enabled
// cycles. Each tick moves a down-counter (COUNT) toward expiry. On expiry the
// timer raises a sticky pending flag, which software clears by writing 1.
// A second expiry while pending is still set raises the overrun flag.
// In periodic mode COUNT reloads from RELOAD; in one-shot mode the timer
// disables itself.
//
// Register map (byte offsets from BASE_ADDRESS):
//   0x00 CONTROL   bit0 enable, bit1 periodic, bit2 irq_en
//   0x04 PRESCALE  [PRESCALE_WIDTH-1:0]
//   0x08 RELOAD    [COUNTER_WIDTH-1:0]
//   0x0C COUNT     live value, write loads it
//   0x10 STATUS    bit0 pending, bit1 overrun (write-1-to-clear)
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   io_write_en    IO write strobe, one cycle per access
//   io_read_en     IO read strobe, one cycle per access
//   io_address     IO byte address
//   io_write_data  IO write data
//   io_read_data   registered read data, valid the cycle after io_read_en
//   interrupt_req  level interrupt (pending & irq_en)

module io_interval_timer #(
  parameter logic [31:0] BASE_ADDRESS   = 32'hffff1100,
  parameter int          COUNTER_WIDTH  = 32,
  parameter int          PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        interrupt_req
);

  localparam logic [COUNTER_WIDTH-1:0]  COUNT_ONE    = COUNTER_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE = PRESCALE_WIDTH'(1);

  logic                      enable;
  logic                      periodic;
  logic                      irq_en;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] prescale_count;
  logic [COUNTER_WIDTH-1:0]  reload;
  logic [COUNTER_WIDTH-1:0]  count;
  logic                      pending;
  logic                      overrun;

  logic sel_control;
  logic sel_prescale;
  logic sel_reload;
  logic sel_count;
  logic sel_status;
  logic wr_control;
  logic wr_prescale;
  logic wr_reload;
  logic wr_count;
  logic wr_status;
  logic tick;
  logic expiry;
  logic enable_rise;
  logic [31:0] read_value;

  // Full 32-bit address decode; anything else is ignored on write and reads 0.
  assign sel_control  = (io_address == BASE_ADDRESS);
  assign sel_prescale = (io_address == BASE_ADDRESS + 32'h04);
  assign sel_reload   = (io_address == BASE_ADDRESS + 32'h08);
  assign sel_count    = (io_address == BASE_ADDRESS + 32'h0c);
  assign sel_status   = (io_address == BASE_ADDRESS + 32'h10);

  assign wr_control  = io_write_en & sel_control;
  assign wr_prescale = io_write_en & sel_prescale;
  assign wr_reload   = io_write_en & sel_reload;
  assign wr_count    = io_write_en & sel_count;
  assign wr_status   = io_write_en & sel_status;

  // A COUNT write in a tick cycle discards that tick, so it cannot expire.
  assign tick        = enable & (prescale_count == '0);
  assign expiry      = tick & ~wr_count & (count == COUNT_ONE);
  assign enable_rise = wr_control & io_write_data[0] & ~enable;

  // Interrupt comes only from registered state, never from the bus inputs.
  assign interrupt_req = pending & irq_en;

  // CONTROL register. A one-shot expiry clears enable, but an explicit
  // CONTROL write in the same cycle takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
    end else if (wr_control) begin
      enable   <= io_write_data[0];
      periodic <= io_write_data[1];
      irq_en   <= io_write_data[2];
    end else if (expiry && !periodic) begin
      enable <= 1'b0;
    end
  end

  // PRESCALE and RELOAD are plain software-written registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      reload   <= '0;
    end else begin
      if (wr_prescale) prescale <= io_write_data[PRESCALE_WIDTH-1:0];
      if (wr_reload)   reload   <= io_write_data[COUNTER_WIDTH-1:0];
    end
  end

  // Prescaler: restarts its period when the timer is switched on and after
  // every tick (including a tick discarded by a COUNT write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_count <= '0;
    end else if (enable_rise || tick) begin
      prescale_count <= prescale;
    end else if (enable) begin
      prescale_count <= prescale_count - PRESCALE_ONE;
    end
  end

  // Down-counter. A COUNT of zero stalls until software writes a new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= io_write_data[COUNTER_WIDTH-1:0];
    end else if (tick) begin
      if (count == COUNT_ONE) begin
        count <= periodic ? reload : '0;
      end else if (count != '0) begin
        count <= count - COUNT_ONE;
      end
    end
  end

  // Sticky status flags. Setting beats a same-cycle write-1-to-clear, and
  // overrun looks at pending as it stood before any clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (expiry) begin
        pending <= 1'b1;
      end else if (wr_status && io_write_data[0]) begin
        pending <= 1'b0;
      end
      if (expiry && pending) begin
        overrun <= 1'b1;
      end else if (wr_status && io_write_data[1]) begin
        overrun <= 1'b0;
      end
    end
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    read_value = 32'h0;
    if (sel_control) begin
      read_value = {29'h0, irq_en, periodic, enable};
    end else if (sel_prescale) begin
      read_value = 32'(prescale);
    end else if (sel_reload) begin
      read_value = 32'(reload);
    end else if (sel_count) begin
      read_value = 32'(count);
    end else if (sel_status) begin
      read_value = {30'h0, overrun, pending};
    end
  end

  // Read data is held until the next read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_read_data <= 32'h0;
    end else if (io_read_en) begin
      io_read_data <= read_value;
    end
  end

endmodule

// File: tb/tb_io_interval_timer.sv
// tb_io_interval_timer
//
// Self-checking bench for io_interval_timer. A behavioural model tracks the
// timer from the register-level rules. The prescaler is modelled as elapsed
// cycles against a captured period. Every falling edge compares io_read_data
// and interrupt_req with the model. Directed scenarios add hand-computed
// literal expectations, and a long randomized phase follows.

module tb_io_interval_timer;

  localparam logic [31:0] BASE = 32'hffff1100;
  localparam logic [31:0] OFF_CONTROL  = 32'h00;
  localparam logic [31:0] OFF_PRESCALE = 32'h04;
  localparam logic [31:0] OFF_RELOAD   = 32'h08;
  localparam logic [31:0] OFF_COUNT    = 32'h0c;
  localparam logic [31:0] OFF_STATUS   = 32'h10;
  localparam logic [31:0] OFF_UNMAPPED = 32'h14;

  logic        clk;
  logic        reset;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        interrupt_req;

  int checks   = 0;
  int failures = 0;

  io_interval_timer #(
    .BASE_ADDRESS  (BASE),
    .COUNTER_WIDTH (32),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_write_en  (io_write_en),
    .io_read_en   (io_read_en),
    .io_address   (io_address),
    .io_write_data(io_write_data),
    .io_read_data (io_read_data),
    .interrupt_req(interrupt_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state.
  logic        m_en      = 1'b0;
  logic        m_per     = 1'b0;
  logic        m_irq     = 1'b0;
  logic        m_pend    = 1'b0;
  logic        m_ovr     = 1'b0;
  logic [15:0] m_pre     = 16'h0;
  logic [15:0] m_period  = 16'h0;
  logic [15:0] m_elapsed = 16'h0;
  logic [31:0] m_rel     = 32'h0;
  logic [31:0] m_cnt     = 32'h0;
  logic [31:0] m_rd      = 32'h0;

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    case (off)
      OFF_CONTROL:  return {29'h0, m_irq, m_per, m_en};
      OFF_PRESCALE: return {16'h0, m_pre};
      OFF_RELOAD:   return m_rel;
      OFF_COUNT:    return m_cnt;
      OFF_STATUS:   return {30'h0, m_ovr, m_pend};
      default:      return 32'h0;
    endcase
  endfunction

  // Model update: a tick happens when the timer has been enabled for
  // "period" cycles since the last tick or since it was switched on.
  always @(posedge clk or posedge reset) begin : model_update
    logic [31:0] off;
    logic        tick;
    logic        expire;
    logic        wr_ctl;
    logic        wr_cnt;
    logic        wr_sts;
    if (reset) begin
      m_en      <= 1'b0;
      m_per     <= 1'b0;
      m_irq     <= 1'b0;
      m_pend    <= 1'b0;
      m_ovr     <= 1'b0;
      m_pre     <= 16'h0;
      m_period  <= 16'h0;
      m_elapsed <= 16'h0;
      m_rel     <= 32'h0;
      m_cnt     <= 32'h0;
      m_rd      <= 32'h0;
    end else begin
      off    = io_address - BASE;
      wr_ctl = io_write_en && (off == OFF_CONTROL);
      wr_cnt = io_write_en && (off == OFF_COUNT);
      wr_sts = io_write_en && (off == OFF_STATUS);
      tick   = m_en && (m_elapsed == m_period);
      expire = tick && !wr_cnt && (m_cnt == 32'd1);

      if (io_read_en) m_rd <= modelRead(io_address);

      if (wr_ctl) begin
        m_en  <= io_write_data[0];
        m_per <= io_write_data[1];
        m_irq <= io_write_data[2];
      end else if (expire && !m_per) begin
        m_en <= 1'b0;
      end

      if (io_write_en && off == OFF_PRESCALE) m_pre <= io_write_data[15:0];
      if (io_write_en && off == OFF_RELOAD)   m_rel <= io_write_data;

      if ((wr_ctl && io_write_data[0] && !m_en) || tick) begin
        m_period  <= m_pre;
        m_elapsed <= 16'h0;
      end else if (m_en) begin
        m_elapsed <= m_elapsed + 16'd1;
      end

      if (wr_cnt) m_cnt <= io_write_data;
      else if (expire) m_cnt <= m_per ? m_rel : 32'h0;
      else if (tick && m_cnt > 32'd1) m_cnt <= m_cnt - 32'd1;

      if (expire) m_pend <= 1'b1;
      else if (wr_sts && io_write_data[0]) m_pend <= 1'b0;

      if (expire && m_pend) m_ovr <= 1'b1;
      else if (wr_sts && io_write_data[1]) m_ovr <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    checks++;
    if (io_read_data !== m_rd) begin
      failures++;
      $display("[TB] FAIL model_read_data t=%0t actual=%h expected=%h",
               $time, io_read_data, m_rd);
    end
    checks++;
    if (interrupt_req !== (m_pend & m_irq)) begin
      failures++;
      $display("[TB] FAIL model_interrupt t=%0t actual=%b expected=%b",
               $time, interrupt_req, m_pend & m_irq);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drives one bus cycle; returns 1ns after the edge that performed it.
  task automatic applyStimulus(input logic we, input logic re,
                               input logic [31:0] addr, input logic [31:0] data);
    io_write_en   = we;
    io_read_en    = re;
    io_address    = addr;
    io_write_data = data;
    @(posedge clk);
    #1;
    io_write_en = 1'b0;
    io_read_en  = 1'b0;
  endtask

  task automatic doWrite(input logic [31:0] off, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, BASE + off, data);
  endtask

  task automatic doRead(input logic [31:0] off);
    applyStimulus(1'b0, 1'b1, BASE + off, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic randomOp();
    logic        we;
    logic        re;
    int          k;
    logic [31:0] addr;
    logic [31:0] data;
    we = ($urandom_range(0, 99) < 35);
    re = ($urandom_range(0, 99) < 40);
    k  = $urandom_range(0, 6);
    addr = (k == 6) ? $urandom : BASE + 32'(k * 4);
    case (k)
      0:       data = 32'($urandom_range(0, 7));
      1:       data = 32'($urandom_range(0, 3));
      2:       data = 32'($urandom_range(0, 6));
      3:       data = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 8));
      4:       data = 32'($urandom_range(0, 3));
      default: data = $urandom;
    endcase
    applyStimulus(we, re, addr, data);
  endtask

  initial begin
    reset         = 1'b0;
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    io_address    = 32'h0;
    io_write_data = 32'h0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_read_data", io_read_data, 32'h0);
    checkOutput("reset_irq", {31'h0, interrupt_req}, 32'h0);

    // Reset mid-count.
    doWrite(OFF_COUNT, 32'd5);
    doWrite(OFF_CONTROL, 32'h1);
    idle(2);
    doRead(OFF_COUNT);
    checkOutput("midcount_value", io_read_data, 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_read_data", io_read_data, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    doRead(OFF_COUNT);
    checkOutput("after_reset_count", io_read_data, 32'h0);
    doRead(OFF_CONTROL);
    checkOutput("after_reset_control", io_read_data, 32'h0);
    doRead(OFF_STATUS);
    checkOutput("after_reset_status", io_read_data, 32'h0);
    checkOutput("after_reset_irq", {31'h0, interrupt_req}, 32'h0);

    // One-shot, prescale 0.
    doWrite(OFF_PRESCALE, 32'd0);
    doWrite(OFF_COUNT, 32'd3);
    doWrite(OFF_CONTROL, 32'h5);
    for (int i = 0; i < 3; i++) begin
      checkOutput("oneshot_irq_low", {31'h0, interrupt_req}, 32'h0);
      idle(1);
    end
    checkOutput("oneshot_irq_high", {31'h0, interrupt_req}, 32'h1);
    doRead(OFF_CONTROL);
    checkOutput("oneshot_control", io_read_data, 32'h4);
    doRead(OFF_COUNT);
    checkOutput("oneshot_count", io_read_data, 32'h0);
    doWrite(OFF_STATUS, 32'h1);
    checkOutput("oneshot_irq_cleared", {31'h0, interrupt_req}, 32'h0);

    // Periodic with prescale 2: expiry every 12 cycles, second one overruns.
    doWrite(OFF_PRESCALE, 32'd2);
    doWrite(OFF_RELOAD, 32'd4);
    doWrite(OFF_COUNT, 32'd4);
    doWrite(OFF_CONTROL, 32'h7);
    idle(11);
    checkOutput("periodic_irq_before", {31'h0, interrupt_req}, 32'h0);
    idle(1);
    checkOutput("periodic_irq_first", {31'h0, interrupt_req}, 32'h1);
    idle(11);
    doRead(OFF_STATUS);
    checkOutput("periodic_status_before_overrun", io_read_data, 32'h1);
    doRead(OFF_STATUS);
    checkOutput("periodic_status_overrun", io_read_data, 32'h3);
    doWrite(OFF_STATUS, 32'h3);
    doWrite(OFF_CONTROL, 32'h0);

    // Read latency, hold, unmapped address.
    doWrite(OFF_COUNT, 32'h1234);
    doRead(OFF_COUNT);
    checkOutput("read_latency", io_read_data, 32'h1234);
    idle(3);
    checkOutput("read_hold", io_read_data, 32'h1234);
    doRead(OFF_UNMAPPED);
    checkOutput("unmapped_read", io_read_data, 32'h0);
    doWrite(OFF_UNMAPPED, 32'hffffffff);
    doRead(OFF_COUNT);
    checkOutput("unmapped_write_count", io_read_data, 32'h1234);
    doRead(OFF_CONTROL);
    checkOutput("unmapped_write_control", io_read_data, 32'h0);
    doRead(OFF_PRESCALE);
    checkOutput("unmapped_write_prescale", io_read_data, 32'h2);
    doRead(OFF_STATUS);
    checkOutput("unmapped_write_status", io_read_data, 32'h0);

    // W1C in the expiry cycle: set wins.
    doWrite(OFF_PRESCALE, 32'd0);
    doWrite(OFF_COUNT, 32'd2);
    doWrite(OFF_CONTROL, 32'h5);
    idle(1);
    doWrite(OFF_STATUS, 32'h1);
    doRead(OFF_STATUS);
    checkOutput("w1c_collision_status", io_read_data, 32'h1);
    checkOutput("w1c_collision_irq", {31'h0, interrupt_req}, 32'h1);
    doWrite(OFF_STATUS, 32'h3);

    // COUNT write on a tick: the write wins.
    doWrite(OFF_COUNT, 32'd20);
    doWrite(OFF_CONTROL, 32'h1);
    doWrite(OFF_COUNT, 32'd9);
    doRead(OFF_COUNT);
    checkOutput("count_write_on_tick", io_read_data, 32'd9);
    doWrite(OFF_CONTROL, 32'h0);

    // Stall with RELOAD=0 and irq gating.
    doWrite(OFF_RELOAD, 32'd0);
    doWrite(OFF_COUNT, 32'd2);
    doWrite(OFF_CONTROL, 32'h3);
    idle(6);
    checkOutput("gated_irq_low", {31'h0, interrupt_req}, 32'h0);
    doRead(OFF_STATUS);
    checkOutput("stall_status", io_read_data, 32'h1);
    doRead(OFF_COUNT);
    checkOutput("stall_count", io_read_data, 32'h0);
    doWrite(OFF_CONTROL, 32'h7);
    checkOutput("irq_enable_raises", {31'h0, interrupt_req}, 32'h1);
    idle(4);
    doRead(OFF_STATUS);
    checkOutput("stall_no_overrun", io_read_data, 32'h1);
    doWrite(OFF_CONTROL, 32'h0);
    doWrite(OFF_STATUS, 32'h3);

    // Randomized phase checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        randomOp();
      end
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
